// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl
//
// Sequencer in front of the operand receive path. It accepts one
// micro-instruction with three operand base addresses and issues exactly four
// read requests in the order A, B, C-low, C-high. That order matches the order
// in which the receiver consumes rd_data words. Accepted micro-instructions are
// queued, so the receiver sees each uinstr in step with its operand set.
// The block bounds the number of outstanding reads and flags protocol errors.
//
// Ports:
//   clk, rst_i                 clock, synchronous active-high reset
//   uinstr_valid_i/ready_o     micro-instruction handshake
//   uinstr_i                   packed micro-instruction
//   addr_a_i/addr_b_i/addr_c_i operand base addresses (C is the low word)
//   rd_addr_valid_o/ready_i    read request handshake
//   rd_addr_o                  read request address
//   rd_data_valid_i            one response word returned
//   rx_uinstr_o/valid_o        head of the uinstr queue for the receiver
//   rx_op_done_i               receiver finished one operand set; pops queue
//   outstanding_o              issued-but-unanswered read count
//   busy_o                     sequencing, reads in flight, or queue non-empty
//   err_o                      sticky protocol error (over-run / empty pop)

module operand_fetch_ctrl #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int UINSTR_W        = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int QDEPTH          = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic                                 uinstr_valid_i,
    output logic                                 uinstr_ready_o,
    input  logic [UINSTR_W-1:0]                  uinstr_i,
    input  logic [ADDR_W-1:0]                    addr_a_i,
    input  logic [ADDR_W-1:0]                    addr_b_i,
    input  logic [ADDR_W-1:0]                    addr_c_i,
    output logic                                 rd_addr_valid_o,
    input  logic                                 rd_addr_ready_i,
    output logic [ADDR_W-1:0]                    rd_addr_o,
    input  logic                                 rd_data_valid_i,
    output logic [UINSTR_W-1:0]                  rx_uinstr_o,
    output logic                                 rx_uinstr_valid_o,
    input  logic                                 rx_op_done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QPTR_W = $clog2(QDEPTH);
    localparam int QCNT_W = $clog2(QDEPTH + 1);

    // C-high is the word after C-low; the add wraps within ADDR_W bits.
    localparam logic [ADDR_W-1:0] C_HI_OFFSET = ADDR_W'(DATA_W / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_A  = 3'd1;
    localparam logic [2:0] S_REQ_B  = 3'd2;
    localparam logic [2:0] S_REQ_CL = 3'd3;
    localparam logic [2:0] S_REQ_CH = 3'd4;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   addr_a_q, addr_b_q, addr_c_q;
    logic [CNT_W-1:0]    out_cnt;
    logic [UINSTR_W-1:0] q_mem [QDEPTH];
    logic [QPTR_W-1:0]   wr_ptr, rd_ptr;
    logic [QCNT_W-1:0]   q_cnt;
    logic                err_q;

    logic q_full, q_empty;
    logic addr_hs, uinstr_hs, q_pop, rsp_dec;

    assign q_full  = (q_cnt == QCNT_W'(QDEPTH));
    assign q_empty = (q_cnt == '0);

    // Ready comes from the registered occupancy, so a pop in the same cycle
    // does not make room for a push until the following cycle.
    assign uinstr_ready_o  = (state == S_IDLE) && !q_full && !rst_i;
    assign rd_addr_valid_o = (state != S_IDLE) && (out_cnt < CNT_W'(MAX_OUTSTANDING));

    assign addr_hs   = rd_addr_valid_o && rd_addr_ready_i;
    assign uinstr_hs = uinstr_valid_i && uinstr_ready_o;
    assign q_pop     = rx_op_done_i && !q_empty;
    // A response with nothing outstanding is an over-run: flagged, never counted.
    assign rsp_dec   = rd_data_valid_i && (out_cnt != '0);

    always_comb begin
        // NOTE: default assignment first so every path drives rd_addr_o and no latch is inferred.
        rd_addr_o = '0;
        case (state)
            S_REQ_A:  rd_addr_o = addr_a_q;
            S_REQ_B:  rd_addr_o = addr_b_q;
            S_REQ_CL: rd_addr_o = addr_c_q;
            S_REQ_CH: rd_addr_o = addr_c_q + C_HI_OFFSET;
            default:  rd_addr_o = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= S_IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            out_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (uinstr_hs) begin
                        addr_a_q <= addr_a_i;
                        addr_b_q <= addr_b_i;
                        addr_c_q <= addr_c_i;
                        state    <= S_REQ_A;
                    end
                end
                S_REQ_A:  if (addr_hs) state <= S_REQ_B;
                S_REQ_B:  if (addr_hs) state <= S_REQ_CL;
                S_REQ_CL: if (addr_hs) state <= S_REQ_CH;
                S_REQ_CH: if (addr_hs) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            case ({addr_hs, rsp_dec})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase

            // QDEPTH is a power of two, so the pointers wrap by overflow.
            if (uinstr_hs) wr_ptr <= wr_ptr + QPTR_W'(1);
            if (q_pop)     rd_ptr <= rd_ptr + QPTR_W'(1);

            case ({uinstr_hs, q_pop})
                2'b10:   q_cnt <= q_cnt + QCNT_W'(1);
                2'b01:   q_cnt <= q_cnt - QCNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase

            if ((rd_data_valid_i && (out_cnt == '0)) || (rx_op_done_i && q_empty))
                err_q <= 1'b1;
        end
    end

    // NOTE: queue storage has no reset; the empty flag masks stale entries, so only pointers and count are reset.
    always_ff @(posedge clk) begin
        if (uinstr_hs) q_mem[wr_ptr] <= uinstr_i;
    end

    assign rx_uinstr_o       = q_empty ? '0 : q_mem[rd_ptr];
    assign rx_uinstr_valid_o = !q_empty;
    assign outstanding_o     = out_cnt;
    assign busy_o            = (state != S_IDLE) || (out_cnt != '0) || !q_empty;
    assign err_o             = err_q;

endmodule
